// File: rtl/m6502_bus_if.sv
// m6502 CPU bus bundle: the address/data/we_n/rdy signals between the core
// and a memory-mapped responder, plus the responder's active-low interrupt.
//
// Signals:
//   addr   [15:0]  CPU address bus                  (master -> slave)
//   wdata  [7:0]   CPU write data                   (master -> slave)
//   we_n           1 = read, 0 = write              (master -> slave)
//   rdata  [7:0]   read data, 0 when not selected   (slave -> master)
//   sel            responder window hit             (slave -> master)
//   rdy            0 = stall the CPU                (slave -> master)
//   irq_n          active-low interrupt request     (slave -> master)
interface m6502_bus_if;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        we_n;
   logic [7:0]  rdata;
   logic        sel;
   logic        rdy;
   logic        irq_n;

   modport master (
      output addr, wdata, we_n,
      input  rdata, sel, rdy, irq_n
   );

   modport slave (
      input  addr, wdata, we_n,
      output rdata, sel, rdy, irq_n
   );
endinterface

// File: rtl/m6502_periph_timer.sv
// m6502_periph_timer: memory-mapped responder on the m6502 bus. Decodes an
// 8-byte window at BASE, stretches reads by WAIT cycles through rdy, and
// hosts a 16-bit reloadable down-counter that raises irq_n on expiry.
//
// Parameters:
//   BASE  window base address (low 3 bits must be 0)
//   WAIT  read wait states, 0..3
// Ports:
//   clk   system clock, rising edge
//   res   synchronous active-high reset
//   bus   m6502_bus_if.slave (addr, wdata, we_n in; rdata, sel, rdy, irq_n out)
//
// Register map (addr[2:0]):
//   0 CTRL      RW  bit0 EN, bit1 IEN, bit2 AUTO
//   1 STATUS        bit0 EXP (write 1 to clear), bit7 EN (RO)
//   2 RELOAD_LO RW
//   3 RELOAD_HI RW  write also loads COUNT <= {wdata, RELOAD_LO}
//   4 COUNT_LO  RO  completing read latches COUNT[15:8] into SHADOW
//   5 COUNT_HI  RO  returns SHADOW
//   6 SCRATCH   RW
//   7 ID        RO  8'h65
module m6502_periph_timer #(
   parameter logic [15:0] BASE = 16'hD000,
   parameter int unsigned WAIT = 1
) (
   input  logic        clk,
   input  logic        res,
   m6502_bus_if.slave  bus
);

   typedef enum logic [2:0] {
      R_CTRL      = 3'd0,
      R_STATUS    = 3'd1,
      R_RELOAD_LO = 3'd2,
      R_RELOAD_HI = 3'd3,
      R_COUNT_LO  = 3'd4,
      R_COUNT_HI  = 3'd5,
      R_SCRATCH   = 3'd6,
      R_ID        = 3'd7
   } reg_off_e;

   localparam logic [1:0] WAIT_C = WAIT[1:0];
   localparam logic [7:0] ID_VAL = 8'h65;

   logic        en, ien, auto_rl, exp_flag;
   logic [15:0] reload, count;
   logic [7:0]  shadow, scratch;
   logic [1:0]  wcnt, wcnt_next;

   reg_off_e    off;
   logic        sel, wr_en, rd_req, rd_wait, rd_done, expire;

   assign off     = reg_off_e'(bus.addr[2:0]);
   assign sel     = (bus.addr[15:3] == BASE[15:3]);
   assign wr_en   = sel & ~bus.we_n;
   assign rd_req  = sel & bus.we_n;
   assign rd_wait = rd_req & (wcnt != WAIT_C);
   assign rd_done = rd_req & (wcnt == WAIT_C);
   // Expiry is evaluated on the pre-edge state so bus writes in the same
   // cycle can be given priority over the timer's own updates.
   assign expire  = en & (count == 16'h0000);

   assign bus.sel   = sel;
   assign bus.rdy   = ~rd_wait;
   // Decoded from registers only: no bus input reaches the interrupt line.
   assign bus.irq_n = ~(exp_flag & ien);

   // Wait counter: counts up while a read is stalled; any completion, abort
   // or non-read cycle returns it to 0 so the next read pays the full WAIT.
   always_comb begin
      // NOTE: default assigned first so every path drives the signal and no latch is inferred.
      wcnt_next = 2'd0;
      if (rd_wait) begin
         wcnt_next = wcnt + 2'd1;
      end
   end

   always_comb begin
      bus.rdata = 8'h00;
      if (sel) begin
         case (off)
            R_CTRL:      bus.rdata = {5'b0, auto_rl, ien, en};
            R_STATUS:    bus.rdata = {en, 6'b0, exp_flag};
            R_RELOAD_LO: bus.rdata = reload[7:0];
            R_RELOAD_HI: bus.rdata = reload[15:8];
            R_COUNT_LO:  bus.rdata = count[7:0];
            R_COUNT_HI:  bus.rdata = shadow;
            R_SCRATCH:   bus.rdata = scratch;
            R_ID:        bus.rdata = ID_VAL;
            default:     bus.rdata = 8'h00;
         endcase
      end
   end

   // Timer updates come first; the bus-write block follows so that, with
   // last-assignment-wins, register writes override the timer for EN and
   // COUNT. EXP clear is explicitly suppressed on an expiry edge instead.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (res) begin
         // NOTE: every register here is small control state, so all of it is reset; there is no memory array.
         en       <= 1'b0;
         ien      <= 1'b0;
         auto_rl  <= 1'b0;
         exp_flag <= 1'b0;
         reload   <= 16'h0000;
         count    <= 16'h0000;
         shadow   <= 8'h00;
         scratch  <= 8'h00;
         wcnt     <= 2'd0;
      end else begin
         wcnt <= wcnt_next;

         if (en) begin
            if (count == 16'h0000) begin
               exp_flag <= 1'b1;
               if (auto_rl) begin
                  count <= reload;
               end else begin
                  en <= 1'b0;
               end
            end else begin
               count <= count - 16'd1;
            end
         end

         if (wr_en) begin
            case (off)
               R_CTRL: begin
                  en      <= bus.wdata[0];
                  ien     <= bus.wdata[1];
                  auto_rl <= bus.wdata[2];
               end
               R_STATUS: begin
                  if (bus.wdata[0] && !expire) begin
                     exp_flag <= 1'b0;
                  end
               end
               R_RELOAD_LO: reload[7:0] <= bus.wdata;
               R_RELOAD_HI: begin
                  reload[15:8] <= bus.wdata;
                  count        <= {bus.wdata, reload[7:0]};
               end
               R_SCRATCH:   scratch <= bus.wdata;
               default: ;
            endcase
         end

         // SHADOW latches only when the COUNT_LO read actually completes.
         if (rd_done && (off == R_COUNT_LO)) begin
            shadow <= count[15:8];
         end
      end
   end

endmodule

// File: tb/tb_m6502_periph_timer.sv
// Testbench for m6502_periph_timer. Three instances share one bus drive:
// WAIT=0 (main register/timer checks), WAIT=2 and WAIT=3 (stall timing).
module tb_m6502_periph_timer;

   localparam logic [15:0] BASE = 16'hD000;

   logic        clk = 1'b0;
   logic        res;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        we_n;

   int n_pass  = 0;
   int n_total = 0;

   m6502_bus_if bus0 ();
   m6502_bus_if bus2 ();
   m6502_bus_if bus3 ();

   assign bus0.addr = addr;  assign bus0.wdata = wdata;  assign bus0.we_n = we_n;
   assign bus2.addr = addr;  assign bus2.wdata = wdata;  assign bus2.we_n = we_n;
   assign bus3.addr = addr;  assign bus3.wdata = wdata;  assign bus3.we_n = we_n;

   m6502_periph_timer #(.BASE(BASE), .WAIT(0)) u_dut0 (.clk(clk), .res(res), .bus(bus0.slave));
   m6502_periph_timer #(.BASE(BASE), .WAIT(2)) u_dut2 (.clk(clk), .res(res), .bus(bus2.slave));
   m6502_periph_timer #(.BASE(BASE), .WAIT(3)) u_dut3 (.clk(clk), .res(res), .bus(bus3.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic       is_wr;
      logic [2:0] off;
      logic [7:0] data;
      logic [7:0] want;
   } vec_t;

   localparam int N_VEC = 24;
   vec_t tbl [N_VEC];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, want);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addr  = 16'h0000;
      we_n  = 1'b1;
      wdata = 8'h00;
   endtask

   task automatic wr(input logic [2:0] off, input logic [7:0] d);
      addr  = BASE + 16'(off);
      we_n  = 1'b0;
      wdata = d;
      step();
      idle();
   endtask

   // Single-cycle read against the WAIT=0 instance.
   task automatic rd_chk(input string name, input logic [2:0] off, input logic [7:0] want);
      addr = BASE + 16'(off);
      we_n = 1'b1;
      #1;
      check(name, 16'(bus0.rdata), 16'(want));
      step();
      idle();
   endtask

   // Out-of-window access: nothing may respond.
   task automatic oow(input logic [15:0] a, input logic wr_n, input logic [7:0] d);
      addr  = a;
      we_n  = wr_n;
      wdata = d;
      #1;
      check($sformatf("oow sel %h", a), 16'(bus0.sel), 16'h0);
      check($sformatf("oow rdy %h", a), 16'({bus0.rdy, bus2.rdy}), 16'h3);
      check($sformatf("oow rdata %h", a), 16'(bus0.rdata), 16'h00);
      step();
      idle();
   endtask

   initial begin
      tbl[0]  = '{1'b0, 3'd7, 8'h00, 8'h65};
      tbl[1]  = '{1'b0, 3'd0, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 3'd1, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 3'd2, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 3'd3, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 3'd4, 8'h00, 8'h00};
      tbl[6]  = '{1'b0, 3'd5, 8'h00, 8'h00};
      tbl[7]  = '{1'b0, 3'd6, 8'h00, 8'h00};
      tbl[8]  = '{1'b1, 3'd6, 8'hA5, 8'h00};
      tbl[9]  = '{1'b0, 3'd6, 8'h00, 8'hA5};
      tbl[10] = '{1'b1, 3'd2, 8'hC3, 8'h00};
      tbl[11] = '{1'b0, 3'd2, 8'h00, 8'hC3};
      tbl[12] = '{1'b1, 3'd0, 8'hF8, 8'h00};
      tbl[13] = '{1'b0, 3'd0, 8'h00, 8'h00};
      tbl[14] = '{1'b1, 3'd0, 8'h02, 8'h00};
      tbl[15] = '{1'b0, 3'd0, 8'h00, 8'h02};
      tbl[16] = '{1'b1, 3'd7, 8'h00, 8'h00};
      tbl[17] = '{1'b0, 3'd7, 8'h00, 8'h65};
      tbl[18] = '{1'b1, 3'd4, 8'hFF, 8'h00};
      tbl[19] = '{1'b0, 3'd4, 8'h00, 8'h00};
      tbl[20] = '{1'b1, 3'd1, 8'h80, 8'h00};
      tbl[21] = '{1'b0, 3'd1, 8'h00, 8'h00};
      tbl[22] = '{1'b1, 3'd0, 8'h00, 8'h00};
      tbl[23] = '{1'b0, 3'd0, 8'h00, 8'h00};

      idle();
      res = 1'b1;
      step();
      step();
      res = 1'b0;
      #1;
      check("reset sel", 16'(bus0.sel), 16'h0);
      check("reset rdy", 16'(bus0.rdy), 16'h1);
      check("reset rdata", 16'(bus0.rdata), 16'h00);
      check("reset irq_n", 16'(bus0.irq_n), 16'h1);

      // Register map and RO behaviour.
      for (int i = 0; i < N_VEC; i++) begin
         if (tbl[i].is_wr) wr(tbl[i].off, tbl[i].data);
         else rd_chk($sformatf("tbl%0d off%0d", i, tbl[i].off), tbl[i].off, tbl[i].want);
      end

      // Out-of-window reads and writes leave everything untouched.
      oow(BASE + 16'd8, 1'b1, 8'h00);
      oow(BASE - 16'd1, 1'b1, 8'h00);
      oow(BASE + 16'd8, 1'b0, 8'hFF);
      oow(BASE + 16'd11, 1'b0, 8'hFF);
      oow(BASE + 16'd14, 1'b0, 8'hFF);
      oow(BASE - 16'd2, 1'b0, 8'hFF);
      oow(BASE - 16'd8, 1'b0, 8'hFF);
      rd_chk("oow ctrl kept", 3'd0, 8'h00);
      rd_chk("oow scratch kept", 3'd6, 8'hA5);
      rd_chk("oow reload kept", 3'd2, 8'hC3);
      rd_chk("oow count kept", 3'd4, 8'h00);

      // SHADOW holds the high byte captured by the COUNT_LO read.
      wr(3'd2, 8'h34);
      wr(3'd3, 8'h12);
      rd_chk("count lo 34", 3'd4, 8'h34);
      wr(3'd3, 8'h56);
      rd_chk("shadow 12", 3'd5, 8'h12);
      rd_chk("count lo again", 3'd4, 8'h34);
      rd_chk("shadow 56", 3'd5, 8'h56);

      // One-shot: RELOAD=3 expires on the 4th edge after EN=1.
      wr(3'd2, 8'h03);
      wr(3'd3, 8'h00);
      wr(3'd0, 8'h03);
      repeat (3) step();
      check("oneshot irq edge3", 16'(bus0.irq_n), 16'h1);
      step();
      check("oneshot irq edge4", 16'(bus0.irq_n), 16'h0);
      rd_chk("oneshot status", 3'd1, 8'h01);
      rd_chk("oneshot ctrl", 3'd0, 8'h02);
      rd_chk("oneshot count lo", 3'd4, 8'h00);
      rd_chk("oneshot count hi", 3'd5, 8'h00);
      wr(3'd1, 8'h01);
      check("oneshot irq cleared", 16'(bus0.irq_n), 16'h1);

      // AUTO: RELOAD=2 expires every 3 cycles; a clear on an expiry edge loses.
      wr(3'd2, 8'h02);
      wr(3'd3, 8'h00);
      wr(3'd0, 8'h07);
      repeat (2) step();
      check("auto irq A2", 16'(bus0.irq_n), 16'h1);
      step();
      check("auto irq A3", 16'(bus0.irq_n), 16'h0);
      wr(3'd1, 8'h01);
      check("auto clear A4", 16'(bus0.irq_n), 16'h1);
      step();
      check("auto irq A5", 16'(bus0.irq_n), 16'h1);
      wr(3'd1, 8'h01);
      check("auto set wins A6", 16'(bus0.irq_n), 16'h0);
      wr(3'd0, 8'h00);
      wr(3'd1, 8'h01);

      // CTRL write on a one-shot expiry edge keeps EN.
      wr(3'd2, 8'h00);
      wr(3'd3, 8'h00);
      wr(3'd0, 8'h01);
      wr(3'd0, 8'h03);
      rd_chk("ctrl wins status", 3'd1, 8'h81);
      rd_chk("ctrl wins later", 3'd1, 8'h01);
      wr(3'd0, 8'h00);
      wr(3'd1, 8'h01);

      // RELOAD_HI write on an AUTO expiry edge: written value loads COUNT.
      wr(3'd2, 8'h05);
      wr(3'd0, 8'h05);
      wr(3'd3, 8'h01);
      wr(3'd0, 8'h00);
      rd_chk("rhi wins count lo", 3'd4, 8'h04);
      rd_chk("rhi wins count hi", 3'd5, 8'h01);
      rd_chk("rhi wins exp", 3'd1, 8'h01);
      wr(3'd1, 8'h01);

      // Read wait states: WAIT=2 vs WAIT=0, held read of ID.
      step();
      addr = BASE + 16'd7;
      we_n = 1'b1;
      #1;
      check("w0 rdy c1", 16'(bus0.rdy), 16'h1);
      check("w0 rdata c1", 16'(bus0.rdata), 16'h65);
      check("w2 rdy c1", 16'(bus2.rdy), 16'h0);
      step();
      check("w2 rdy c2", 16'(bus2.rdy), 16'h0);
      step();
      check("w2 rdy c3", 16'(bus2.rdy), 16'h1);
      check("w2 rdata c3", 16'(bus2.rdata), 16'h65);
      step();
      check("w2 b2b rdy c1", 16'(bus2.rdy), 16'h0);
      step();
      check("w2 b2b rdy c2", 16'(bus2.rdy), 16'h0);
      step();
      check("w2 b2b rdy c3", 16'(bus2.rdy), 16'h1);
      idle();
      step();

      // Reset in the middle of a WAIT=3 stall.
      wr(3'd6, 8'hA5);
      wr(3'd2, 8'h00);
      wr(3'd3, 8'h00);
      wr(3'd0, 8'h03);
      step();
      check("pre-res irq_n", 16'(bus3.irq_n), 16'h0);
      addr = BASE + 16'd6;
      we_n = 1'b1;
      #1;
      check("w3 rdy c1", 16'(bus3.rdy), 16'h0);
      step();
      check("w3 rdy c2", 16'(bus3.rdy), 16'h0);
      check("w3 scratch pre-res", 16'(bus3.rdata), 16'hA5);
      step();
      res = 1'b1;
      step();
      res = 1'b0;
      check("res irq_n", 16'(bus3.irq_n), 16'h1);
      check("res scratch", 16'(bus3.rdata), 16'h00);
      check("res w0 irq_n", 16'(bus0.irq_n), 16'h1);
      check("res rdy r1", 16'(bus3.rdy), 16'h0);
      step();
      check("res rdy r2", 16'(bus3.rdy), 16'h0);
      step();
      check("res rdy r3", 16'(bus3.rdy), 16'h0);
      step();
      check("res rdy r4", 16'(bus3.rdy), 16'h1);
      check("res rdata r4", 16'(bus3.rdata), 16'h00);
      idle();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/m6502_periph_timer.md
# m6502_periph_timer

Memory-mapped bus responder for the m6502 CPU bus: the slave end of the address/data/we_n/rdy interface the core drives. It decodes an 8-byte window, inserts programmable read wait states via `rdy`, and hosts a 16-bit reloadable down-counter timer that interrupts the CPU through `irq_n`. It sits in the system bus fabric beside RAM/ROM; `rdata`/`sel` feed the CPU read-data mux, and `irq_n` is wired-AND into the core's interrupt input.

## Interface
- `BASE`, 16'hD000, window base address; low 3 bits must be 0.
- `WAIT`, 1, read wait states, 0–3.
- `clk`  in  1  system clock, all logic on rising edge.
- `res`  in  1  reset, synchronous, active-high.
- `addr`  in  16  CPU address bus.
- `wdata`  in  8  CPU write data (core `datao`).
- `we_n`  in  1  1 = read, 0 = write.
- `rdata`  out  8  read data to the CPU `datai` mux; 0 when `sel`=0.
- `sel`  out  1  combinational window hit: `addr[15:3]==BASE[15:3]`.
- `rdy`  out  1  0 = stall CPU; 1 when not selected.
- `irq_n`  out  1  active-low interrupt request.

## Operation
- Registers at offset `addr[2:0]`:
  - 0 CTRL, RW: bit0 EN, bit1 IEN, bit2 AUTO. Bits 7:3 read 0.
  - 1 STATUS: bit0 EXP flag, write-1-to-clear; bit7 = EN (RO).
  - 2 RELOAD_LO, RW.
  - 3 RELOAD_HI, RW. A write also loads COUNT <= {wdata, RELOAD_LO}.
  - 4 COUNT_LO, RO. A completing read latches COUNT[15:8] into SHADOW.
  - 5 COUNT_HI, RO. Returns SHADOW.
  - 6 SCRATCH, RW.
  - 7 ID, RO, 8'h65.
- Writes to RO registers are ignored.
- Reset values: all registers, COUNT, SHADOW, EXP and the wait counter are 0. After reset: `irq_n`=1, `rdy`=1 when not selected, `rdata`=0 when not selected.
- Timer, each clock with EN=1:
  - If COUNT==0: EXP <= 1. If AUTO=1, COUNT <= RELOAD; otherwise EN <= 0 and COUNT stays 0.
  - Otherwise COUNT <= COUNT-1, wrapping is impossible.
  - Period is RELOAD+1 cycles. RELOAD=0 with AUTO=1 expires every cycle.
- `irq_n = ~(EXP & IEN)`, decoded from registers only; no combinational path from bus inputs.
- Simultaneous events:
  - EXP set and a STATUS write-1 clear in the same cycle: set wins.
  - RELOAD_HI write and expiry in the same cycle: the write load of COUNT wins, and EXP is still set.
  - CTRL write and expiry in the same cycle: the CTRL write value wins for EN.
- Out-of-window: `sel`=0, `rdy`=1, `rdata`=0, no state change.

## Timing
- Writes never stall. The register updates at the clock edge where `sel`=1 and `we_n`=0, regardless of WAIT.
- Read wait FSM uses a 2-bit counter `wcnt`.
  - `rdy = ~(sel & we_n & (wcnt != WAIT))`, combinational.
  - While `sel & we_n & wcnt != WAIT`: `wcnt` increments.
  - When `wcnt == WAIT`: the read completes in that cycle, `rdata` is valid, side effects apply (SHADOW latch), and `wcnt` <= 0.
  - If `sel` drops or `we_n` goes low: `wcnt` <= 0 (aborted access, no side effects).
- A read costs WAIT+1 cycles; `rdy` is low for exactly WAIT cycles. With WAIT=0, `rdy` stays 1 and reads are single-cycle.
- Back-to-back reads of the same address each incur the full WAIT stall.
- `rdata` is combinational from registers and `addr`. It is only guaranteed valid in the completing cycle.
- `res` mid-stall clears `wcnt` and all state at that edge; a still-present read restarts the full WAIT count.

## Test plan
- WAIT=2, read BASE+7 held: `rdy` is 0,0,1 and `rdata`=8'h65 in cycle 3. Repeat with WAIT=0: `rdy` stays 1, data is valid in cycle 1.
- Write RELOAD_LO=03, RELOAD_HI=00, then CTRL=03: EXP sets on the 4th edge after EN=1, `irq_n` goes 0, and EN clears with COUNT=0. Write STATUS=01: `irq_n` returns to 1.
- AUTO mode, RELOAD=0002, CTRL=07: EXP sets every 3 cycles. Hold a STATUS=01 write on an expiry edge: EXP stays 1.
- COUNT=0x1234 with EN=0: read BASE+4 returns 34, write RELOAD_HI=56, read BASE+5 returns 12 (SHADOW, not the new 56).
- Assert `res` during a WAIT=3 read of SCRATCH (previously written A5): all outputs return to reset values. After `res` drops, the still-present read takes 3 stall cycles and returns 00.
- Access addr=BASE+8 and BASE-1 with reads and writes: `sel`=0, `rdy`=1, `rdata`=0, all registers unchanged.
